imm_encoder: RTL
================

// Module: imm_encoder
// PURPOSE
//  Inverse of the immediate generator: packs opcode, register fields, funct3/funct7 and a 32-bit immediate into a 32-bit RV32I instruction word.
//  Format select uses the same 3-bit code as sext_op: I/S/B/J/U.
//  Checks immediate range and alignment; feeds the self-test instruction loader (writes instruction RAM) over valid/ready.
//  Two-stage pipeline with full backpressure.
// PARAMETERS
//  CNT_W    16  width of the encoded-count and error-count counters (saturating)
// PORTS
//  clk        in   1   single clock; all state on rising edge
//  rst_n      in   1   synchronous active-low reset
//  in_valid   in   1   request valid
//  in_ready   out  1   request accepted when in_valid&&in_ready
//  in_fmt     in   3   000 I, 001 S, 010 B, 011 J, 100 U, others illegal
//  in_opcode  in   7   -> inst[6:0]
//  in_rd      in   5   -> inst[11:7] (I/J/U only)
//  in_funct3  in   3   -> inst[14:12] (I/S/B only)
//  in_rs1     in   5   -> inst[19:15] (I/S/B only)
//  in_rs2     in   5   -> inst[24:20] (S/B only)
//  in_imm     in   32  immediate value, two's complement (U: full value incl. low 12 bits)
//  out_valid  out  1   instruction word valid
//  out_ready  in   1   consumer ready
//  out_inst   out  32  encoded instruction
//  out_err    out  1   this word's immediate failed range/alignment or fmt illegal
//  err_sticky out  1   set on any emitted out_err; cleared only by clr or reset
//  clr        in   1   synchronous clear of err_sticky and both counters
//  enc_cnt    out  CNT_W  words emitted (out_valid&&out_ready), saturates at all-ones
//  err_cnt    out  CNT_W  emitted words with out_err=1, saturates
// BEHAVIOUR
//  Reset (rst_n=0 at edge): s1_valid=s2_valid=0, out_valid=0, out_inst=0, out_err=0, err_sticky=0, counters=0.
//   in_ready=1 the cycle after reset; reset mid-operation drops in-flight words silently.
//  Pipeline: S1 registers request + packed word + err; S2 is the output register.
//   Latency accept -> out_valid = 2 cycles with no stall; throughput 1/cycle.
//  s2_load = s1_valid && (!s2_valid || out_ready); in_ready = !s1_valid || s2_load.
//   out_* held stable while out_valid && !out_ready; order strictly preserved; no drops or duplicates.
//  Packing (unused field bits = 0):
//   I: [31:20]=imm[11:0]
//   S: [31:25]=imm[11:5], [11:7]=imm[4:0]
//   B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]
//   J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
//   U: [31:12]=imm[31:12]
//  Error rules:
//   I/S: imm outside -2048..2047
//   B: imm outside -4096..4094 or imm[0]=1
//   J: imm outside -2^20..2^20-2 or imm[0]=1
//   U: imm[11:0]!=0
//   fmt 101..111: out_inst = {25'b0, opcode}
//   Erroneous words are still emitted with truncated packing and out_err=1.
//  Counters: count on the out handshake; clr in the same cycle as a handshake wins (result 0).
//   err_sticky sets on a handshake with out_err=1 unless clr is also high.
// STRUCTURE
//  Shared package rv_enc_pkg: FMT_I..FMT_U codes (shared with sext), field bit-position localparams, range limits.
//  One sub-module, imm_pack: combinational fmt+fields+imm -> {inst, err}, used in S1.
//   Pipeline, handshake and counters stay in imm_encoder.
// TESTING
//  I fmt, op=0010011, rd=1, f3=0, rs1=0, imm=0xFFFFFFFF -> out_inst=0xFFF00093, err=0, 2 cycles after accept.
//  S fmt, op=0100011, f3=2, rs1=1, rs2=2, imm=8 -> 0x0020A423.
//  B fmt, op=1100011, rs1=rs2=0, f3=0, imm=-4 -> 0xFE000EE3.
//  J fmt, op=1101111, rd=1, imm=8 -> 0x008000EF.
//  B imm=3, then I imm=2048 -> both out_err=1, err_cnt=2, err_sticky=1; clr -> all 0.
//  Stream 4 words with out_ready=0 for 5 cycles -> in_ready low after 2 accepts, all 4 emitted in order, enc_cnt=4.
//  Assert rst_n=0 with both stages full -> out_valid=0 next cycle, nothing later emitted.

Source files
------------

// File: rtl/rv_enc_pkg.sv
// RV32I instruction-format codes (shared with the sign-extension unit),
// field bit positions and immediate range limits for the encoder.
package rv_enc_pkg;

  typedef enum logic [2:0] {
    FMT_I = 3'b000,
    FMT_S = 3'b001,
    FMT_B = 3'b010,
    FMT_J = 3'b011,
    FMT_U = 3'b100
  } fmt_e;

  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned F3_LSB  = 12;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS2_LSB = 20;
  localparam int unsigned F7_LSB  = 25;

  localparam int signed IMM_IS_MIN = -2048;
  localparam int signed IMM_IS_MAX = 2047;
  localparam int signed IMM_B_MIN  = -4096;
  localparam int signed IMM_B_MAX  = 4094;
  localparam int signed IMM_J_MIN  = -1048576;
  localparam int signed IMM_J_MAX  = 1048574;

  function automatic logic imm_in_range(input logic [31:0] v, input int signed lo,
                                        input int signed hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// Combinational packer: format + register fields + immediate -> instruction
// word, plus range/alignment/illegal-format error flag.
module imm_pack
  import rv_enc_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] inst_o,
  output logic        err_o
);

  always_comb begin
    inst_o                 = '0;
    err_o                  = 1'b0;
    inst_o[OPC_LSB +: 7]   = opcode_i;
    case (fmt_i)
      FMT_I: begin
        inst_o[RD_LSB  +: 5]  = rd_i;
        inst_o[F3_LSB  +: 3]  = funct3_i;
        inst_o[RS1_LSB +: 5]  = rs1_i;
        inst_o[31:20]         = imm_i[11:0];
        err_o = !imm_in_range(imm_i, IMM_IS_MIN, IMM_IS_MAX);
      end
      FMT_S: begin
        inst_o[RD_LSB  +: 5]  = imm_i[4:0];
        inst_o[F3_LSB  +: 3]  = funct3_i;
        inst_o[RS1_LSB +: 5]  = rs1_i;
        inst_o[RS2_LSB +: 5]  = rs2_i;
        inst_o[F7_LSB  +: 7]  = imm_i[11:5];
        err_o = !imm_in_range(imm_i, IMM_IS_MIN, IMM_IS_MAX);
      end
      FMT_B: begin
        inst_o[7]             = imm_i[11];
        inst_o[11:8]          = imm_i[4:1];
        inst_o[F3_LSB  +: 3]  = funct3_i;
        inst_o[RS1_LSB +: 5]  = rs1_i;
        inst_o[RS2_LSB +: 5]  = rs2_i;
        inst_o[30:25]         = imm_i[10:5];
        inst_o[31]            = imm_i[12];
        err_o = !imm_in_range(imm_i, IMM_B_MIN, IMM_B_MAX) || imm_i[0];
      end
      FMT_J: begin
        inst_o[RD_LSB  +: 5]  = rd_i;
        inst_o[19:12]         = imm_i[19:12];
        inst_o[20]            = imm_i[11];
        inst_o[30:21]         = imm_i[10:1];
        inst_o[31]            = imm_i[20];
        err_o = !imm_in_range(imm_i, IMM_J_MIN, IMM_J_MAX) || imm_i[0];
      end
      FMT_U: begin
        inst_o[RD_LSB  +: 5]  = rd_i;
        inst_o[31:12]         = imm_i[31:12];
        err_o = (imm_i[11:0] != 12'd0);
      end
      default: begin
        // illegal format: opcode only
        err_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready instruction encoder with saturating emitted/error
// counters and a sticky error flag for the self-test instruction loader.
module imm_encoder
  import rv_enc_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [2:0]       in_funct3,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic             err_sticky,
  input  logic             clr,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      pack_inst;
  logic             pack_err;
  logic             s1_valid_q, s1_err_q;
  logic [31:0]      s1_inst_q;
  logic             s2_valid_q, s2_err_q;
  logic [31:0]      s2_inst_q;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d, err_cnt_q, err_cnt_d;
  logic             s2_load, in_fire, out_fire;

  imm_pack u_pack (
    .fmt_i    (in_fmt),
    .opcode_i (in_opcode),
    .rd_i     (in_rd),
    .funct3_i (in_funct3),
    .rs1_i    (in_rs1),
    .rs2_i    (in_rs2),
    .imm_i    (in_imm),
    .inst_o   (pack_inst),
    .err_o    (pack_err)
  );

  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid_q && out_ready;

  // clr takes priority over a simultaneous handshake
  always_comb begin
    enc_cnt_d = enc_cnt_q;
    err_cnt_d = err_cnt_q;
    sticky_d  = sticky_q;
    if (clr) begin
      enc_cnt_d = '0;
      err_cnt_d = '0;
      sticky_d  = 1'b0;
    end else if (out_fire) begin
      if (enc_cnt_q != '1) enc_cnt_d = enc_cnt_q + CNT_ONE;
      if (s2_err_q) begin
        sticky_d = 1'b1;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_inst_q  <= '0;
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_inst_q  <= '0;
      s2_err_q   <= 1'b0;
      sticky_q   <= 1'b0;
      enc_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (in_fire) begin
        s1_valid_q <= 1'b1;
        s1_inst_q  <= pack_inst;
        s1_err_q   <= pack_err;
      end else if (s2_load) begin
        s1_valid_q <= 1'b0;
      end
      if (s2_load) begin
        s2_valid_q <= 1'b1;
        s2_inst_q  <= s1_inst_q;
        s2_err_q   <= s1_err_q;
      end else if (out_ready) begin
        s2_valid_q <= 1'b0;
      end
      sticky_q  <= sticky_d;
      enc_cnt_q <= enc_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_inst   = s2_inst_q;
  assign out_err    = s2_err_q;
  assign err_sticky = sticky_q;
  assign enc_cnt    = enc_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule
